// File: rtl/mem_pkg.sv
// Shared definitions for the main_memory request controller.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths (match main_memory)
//   state_t                 : controller FSM state encoding
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssueW = 3'd1,
        StIssueR = 3'd2,
        StWait   = 3'd3,
        StResp   = 3'd4
    } state_t;

endpackage

// File: rtl/req_fifo.sv
// In-order synchronous request FIFO.
//   clk, reset       : clock (rising edge), asynchronous active-low reset
//   push, wdata      : write side; push is ignored while full
//   pop, rdata       : read side; rdata is the current head, pop is ignored while empty
//   full, empty      : occupancy flags derived from count
//   count            : number of stored entries (0..DEPTH)
module req_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request controller in front of main_memory.
//   clk, reset                       : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready              : core request handshake
//   req_write, req_addr, req_wdata   : request payload (store data ignored for loads)
//   resp_valid/resp_ready, resp_rdata: load response channel
//   mem_address, mem_data_in         : registered address/data to main_memory
//   mem_write_enable/mem_read_enable : registered single-cycle memory strobes
//   mem_data_out                     : memory read data, valid the cycle after a read strobe
//   idle                             : nothing queued, in flight, or awaiting acceptance
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              idle
);

    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    state_t             state;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               issue;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    assign fifo_wdata = {req_write, req_addr, req_wdata};
    assign head_write = fifo_rdata[ENTRY_W-1];
    assign head_addr  = fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
    assign head_wdata = fifo_rdata[DATA_W-1:0];

    req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid & req_ready),
        .wdata (fifo_wdata),
        .pop   (issue),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // req_ready comes straight from the registered count, so no combinational
    // path exists from any input to it.
    assign req_ready = ~fifo_full;
    assign idle      = (fifo_count == '0) & (state == StIdle) & ~resp_valid;

    // Pop the head whenever the FSM is free to start a new access this cycle.
    always_comb begin
        issue = 1'b0;
        unique case (state)
            StIdle, StIssueW: issue = ~fifo_empty;
            StResp:           issue = resp_ready & ~fifo_empty;
            default:          issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= StIdle;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
        end else begin
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;

            unique case (state)
                StIdle, StIssueW: state <= StIdle;
                StIssueR:         state <= StWait;
                StWait: begin
                    resp_rdata <= mem_data_out;
                    resp_valid <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Starting an access overrides the fall-back transition above.
            if (issue) begin
                mem_address <= head_addr;
                if (head_write) begin
                    mem_data_in      <= head_wdata;
                    mem_write_enable <= 1'b1;
                    state            <= StIssueW;
                end else begin
                    mem_read_enable <= 1'b1;
                    state           <= StIssueR;
                end
            end
        end
    end

endmodule
